regfile_dump: RTL and testbench

Register-file dump sequencer for the pipelined CPU. It sweeps the register file's debug read port (`debug_addr` / `debug_data`) over a requested address range and streams each register's value out over a valid/ready handshake. The stream goes to the board-level debug/IO path. It sits beside the ID-stage register file and never touches the architectural read or write ports.

---
 rtl/regfile_dump_if.sv | 31 +++
 rtl/regfile_dump.sv | 107 ++++++++++
 tb/tb_regfile_dump.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Debug read port of the register file plus the outgoing dump stream.
// Latency: none, wires only.
// Backpressure: out_ready from the consumer stalls the stream; the debug port has none.
interface regfile_dump_if;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;

    // Sequencer side: drives the debug address and the stream.
    modport master (
        output dbg_addr,
        input  dbg_data,
        output out_valid,
        input  out_ready,
        output out_addr,
        output out_data
    );

    // Register file / consumer side.
    modport slave (
        input  dbg_addr,
        output dbg_data,
        input  out_valid,
        output out_ready,
        input  out_addr,
        input  out_data
    );
endinterface

// File: rtl/regfile_dump.sv
// Sweeps the register-file debug port over [first..last] (wrapping 31->0) and streams each value.
// Latency: first beat valid 2 cycles after start; one beat per 2 cycles with out_ready held high.
// Backpressure: beat held stable while out_ready=0; abort drops the stream at the next edge.
module regfile_dump (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  first,
    input  logic [4:0]  last,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    regfile_dump_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cur_q;
    logic [4:0]  cur_d;
    logic [4:0]  end_q;
    logic        busy_q;
    logic        done_q;
    logic        out_valid_q;
    logic [4:0]  out_addr_q;
    logic [31:0] out_data_q;

    // Next register address; 5-bit arithmetic wraps 31 -> 0 on its own.
    always_comb begin
        cur_d = cur_q + 5'd1;
    end

    // Sequencer FSM: all outputs except dbg_addr are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= 5'd0;
            end_q       <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= 5'd0;
            out_data_q  <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // start beats a concurrent abort here; abort alone is ignored.
                    if (start) begin
                        cur_q   <= first;
                        end_q   <= last;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        // Snapshot: value as seen by the debug port during this cycle.
                        out_data_q  <= bus.dbg_data;
                        out_addr_q  <= cur_q;
                        out_valid_q <= 1'b1;
                        state_q     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // abort outranks a handshake in the same cycle, and suppresses done.
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (cur_q == end_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            cur_q   <= cur_d;
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    // Debug address is decoded from state only, so no input reaches it combinationally.
    assign bus.dbg_addr  = (state_q == S_IDLE) ? 5'd0 : cur_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: behavioural register file plus a range/scoreboard model.
// Latency: checks 2-cycle first-beat latency and 2-cycle beat spacing.
// Backpressure: random and directed out_ready stalls, abort and reset mid-dump.
module tb_regfile_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  first;
    logic [4:0]  last;
    logic        abort;
    logic        busy;
    logic        done;

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_dat;
    logic [31:0] rf [32];

    int total;
    int bad;
    int cyc;

    regfile_dump_if rif ();

    regfile_dump u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .first (first),
        .last  (last),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .bus   (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: write lands at the edge, debug read has no bypass, x0 reads 0.
    always @(posedge clk) begin
        if (wr_en) rf[wr_addr] <= wr_dat;
    end
    assign rif.dbg_data = (rif.dbg_addr == 5'd0) ? 32'h0 : rf[rif.dbg_addr];

    function automatic logic [31:0] exp_val(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : rf[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] v);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_dat  = v;
        step();
        wr_en   = 1'b0;
    endtask

    // Runs one dump and scores every beat against the range rules.
    task automatic dump(input logic [4:0] f, input logic [4:0] l, input int stall_pct,
                        input int hold, input bit poke, output int cycles);
        int n;
        int k;
        int guard;
        int fv;
        int hold_left;
        logic [4:0] ea;
        n = ((int'(l) - int'(f)) & 31) + 1;
        start = 1'b1;
        first = f;
        last  = l;
        rif.out_ready = 1'b0;
        step();
        start = 1'b0;
        cycles = 0;
        k = 0;
        guard = 0;
        fv = -1;
        hold_left = hold;
        while (k < n && guard < 4000) begin
            start = poke && (guard == 3);
            if (start) begin
                first = 5'($urandom);
                last  = 5'($urandom);
            end
            chk("busy_in_dump", busy, 1);
            chk("no_early_done", done, 0);
            if (rif.out_valid) begin
                if (fv < 0) fv = cycles;
                ea = f + 5'(k);
                chk("beat_addr", rif.out_addr, ea);
                chk("beat_data", rif.out_data, exp_val(ea));
                if (hold_left > 0) begin
                    rif.out_ready = 1'b0;
                    hold_left--;
                end else begin
                    rif.out_ready = ($urandom_range(99) >= stall_pct);
                end
                if (rif.out_ready) k++;
            end else begin
                rif.out_ready = 1'($urandom_range(1));
            end
            step();
            cycles++;
            guard++;
        end
        start = 1'b0;
        rif.out_ready = 1'b0;
        chk("dump_completed", k, n);
        chk("first_vld_lat", fv, 1);
        chk("done_pulse", done, 1);
        chk("busy_clear", busy, 0);
        chk("valid_clear", rif.out_valid, 0);
        chk("dbg_addr_idle", rif.dbg_addr, 0);
    endtask

    initial begin
        int g;
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        first = 5'd0;
        last = 5'd0;
        abort = 1'b0;
        wr_en = 1'b0;
        wr_addr = 5'd0;
        wr_dat = 32'd0;
        rif.out_ready = 1'b0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", rif.out_valid, 0);
        chk("rst_dbg_addr", rif.dbg_addr, 0);
        chk("rst_out_addr", rif.out_addr, 0);
        chk("rst_out_data", rif.out_data, 0);
        rst = 1'b0;
        step();

        // Full dump with x_i = 0x100+i.
        for (int i = 0; i < 32; i++) load(5'(i), 32'h100 + 32'(i));
        dump(5'd0, 5'd31, 0, 0, 1'b0, cyc);
        chk("full_cycles", cyc, 64);
        step();
        chk("done_once", done, 0);

        // Backpressure: first beat held for 5 cycles.
        load(5'd3, 32'hDEADBEEF);
        load(5'd4, 32'h12345678);
        dump(5'd3, 5'd4, 0, 5, 1'b0, cyc);
        chk("bp_cycles", cyc, 9);

        // Wrap 30,31,0,1.
        dump(5'd30, 5'd1, 0, 0, 1'b0, cyc);
        chk("wrap_cycles", cyc, 8);

        // Single beat, then a start raised on the done cycle.
        load(5'd7, 32'hA5A5A5A5);
        dump(5'd7, 5'd7, 0, 0, 1'b0, cyc);
        chk("single_cycles", cyc, 2);
        dump(5'd10, 5'd12, 25, 0, 1'b0, cyc);

        // Abort during the third beat, with a same-cycle handshake.
        start = 1'b1;
        first = 5'd0;
        last = 5'd31;
        rif.out_ready = 1'b1;
        step();
        start = 1'b0;
        g = 0;
        while (!(rif.out_valid && rif.out_addr == 5'd2) && g < 50) begin
            step();
            g++;
        end
        chk("abort_reach", rif.out_addr, 2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        rif.out_ready = 1'b0;
        chk("abort_valid", rif.out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done, 0);
        step();
        step();
        chk("abort_still_idle", busy, 0);
        chk("abort_no_late_done", done, 0);

        // abort alone in IDLE is ignored; start with abort in IDLE wins.
        abort = 1'b1;
        step();
        chk("abort_idle", busy, 0);
        start = 1'b1;
        first = 5'd9;
        last = 5'd9;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_beats_abort", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_fetch", busy, 0);

        // Snapshot: write during x5's FETCH cycle is not seen, nor one after it.
        load(5'd5, 32'h11111111);
        start = 1'b1;
        first = 5'd5;
        last = 5'd5;
        rif.out_ready = 1'b0;
        step();
        start = 1'b0;
        wr_en = 1'b1;
        wr_addr = 5'd5;
        wr_dat = 32'h22222222;
        step();
        wr_dat = 32'h33333333;
        chk("snap_valid", rif.out_valid, 1);
        chk("snap_old", rif.out_data, 32'h11111111);
        step();
        wr_en = 1'b0;
        chk("snap_after_write", rif.out_data, 32'h11111111);
        rif.out_ready = 1'b1;
        step();
        rif.out_ready = 1'b0;
        chk("snap_done", done, 1);
        dump(5'd5, 5'd5, 0, 0, 1'b0, cyc);

        // Randomized ranges, contents, stalls and ignored starts.
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < 4; j++) load(5'($urandom_range(31, 1)), $urandom);
            dump(5'($urandom), 5'($urandom), 30, int'($urandom_range(3)), 1'b1, cyc);
        end

        // Reset mid-dump.
        start = 1'b1;
        first = 5'd0;
        last = 5'd31;
        rif.out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rif.out_ready = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_valid", rif.out_valid, 0);
        chk("mid_rst_dbg_addr", rif.dbg_addr, 0);
        chk("mid_rst_out_addr", rif.out_addr, 0);
        chk("mid_rst_out_data", rif.out_data, 0);
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
